spi_txn_arbiter: RTL
====================

Name: spi_txn_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit SPI transmit engine between NUM_REQ requesters.
- Each requester holds a 16-bit word with a level request. The arbiter picks one, loads the word onto the engine's parallel input and pulses start.
- It then waits for the engine's done, or for a timeout, and returns a one-cycle ack (with error flag) to the winning requester.
- Sits between the system-side word producers and the SPI serialiser that drives spi_sclk/spi_cs_l/spi_data.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_W, 16, SPI word width.
- TIMEOUT, 64, maximum cycles spent in WAIT before the transaction is aborted with error.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; held high until ack.
- req_data  in  NUM_REQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W].
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse to the winner.
- err  out  1  valid with ack: 1 = timeout, 0 = engine completed.
- spi_start  out  1  one-cycle start pulse to the SPI engine.
- spi_word  out  WORD_W  registered word presented to the engine; stable from START until the next grant.
- spi_done  in  1  one-cycle completion pulse from the engine.
- grant_id  out  clog2(NUM_REQ)  index of the current or last winner.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; ack=0, err=0, spi_start=0, spi_word=0, grant_id=0, busy=0.
  - Timer=0; last-grant pointer=NUM_REQ-1, so requester 0 has highest priority first.
- Reset asserted mid-transaction aborts immediately:
  - No ack is issued.
  - A spi_done arriving after reset releases is ignored in IDLE.
- States: IDLE -> START -> WAIT -> DONE -> IDLE.
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning upward from pointer+1, wrapping modulo NUM_REQ.
  - On that edge: latch req_data slice into spi_word, winner into grant_id, go START.
  - If req is zero, stay in IDLE.
- START:
  - spi_start=1 for exactly this cycle.
  - Timer cleared; go WAIT.
- WAIT:
  - If spi_done=1, go DONE with err_next=0.
  - Else, if timer==TIMEOUT-1, go DONE with err_next=1.
  - Else timer+1.
  - spi_done takes priority over timeout in the same cycle.
- DONE:
  - ack[grant_id]=1 and err=err_next for this cycle only.
  - pointer<=grant_id; go IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> spi_start at cycle 1.
  - spi_done in cycle k -> ack in cycle k+1.
  - Minimum request-to-ack is 4 cycles; next grant is no earlier than the cycle after DONE.
- Requester contract:
  - req must stay high and req_data stable until ack.
  - req must be low in the cycle after ack unless a new word is offered.
  - A request dropped before grant is simply not served.
- spi_done outside WAIT is ignored (no state change, no ack).
- Fairness: with all requesters active, grants rotate 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.
- ack is never multi-hot; ack, spi_start and err are all zero outside their defined cycles.

Test Plan:
- Reset then req=4'b0001, data0=16'h0D73; engine model pulses spi_done 33 cycles after spi_start -> spi_start one cycle after req; spi_word=16'h0D73; ack=4'b0001, err=0 exactly one cycle after spi_done; busy low the next cycle.
- req=4'b1111 held continuously with distinct words 16'h0001..16'h0004 -> grant_id sequence 0,1,2,3,0; spi_word matches each winner; exactly one ack per transaction.
- Engine never returns spi_done, TIMEOUT=64 -> ack pulse with err=1 exactly 64 cycles after the WAIT entry cycle; the next requester is granted afterwards.
- spi_done coincident with the timeout cycle -> err=0.
- Stray spi_done while in IDLE -> no ack and no state change.
- reset asserted mid-WAIT (cycle 10 of 33) -> next cycle IDLE, busy=0, no ack; the late spi_done is ignored; the next request is granted starting from requester 0.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI transmit engine between NUM_REQ word producers.
// Each grant runs START -> WAIT (done or timeout) -> DONE, which acks the winner.
module spi_txn_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WORD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        err,
    output logic                        spi_start,
    output logic [WORD_W-1:0]           spi_word,
    input  logic                        spi_done,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              err_q, err_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [WORD_W-1:0] word_q, word_d;

    logic [WORD_W-1:0] words [NUM_REQ];
    logic              win_found;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    idx_v;
    int                idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) words[i] = req_data[i*WORD_W +: WORD_W];
    end

    // Scan upward from the slot after the last winner, wrapping once around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx_v     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_v = IDW'(idx);
            if (!win_found && req[idx_v]) begin
                win_found = 1'b1;
                win_idx   = idx_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            err_q   <= 1'b0;
            ptr_q   <= IDW'(NUM_REQ - 1);
            grant_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    word_d  = words[win_idx];
                    grant_d = win_idx;
                    state_d = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the last allowed cycle still counts as success.
                if (spi_done) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                ptr_d   = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == DONE) ack[grant_q] = 1'b1;
    end

    assign err       = (state_q == DONE) && err_q;
    assign spi_start = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign spi_word  = word_q;
    assign grant_id  = grant_q;

endmodule
